clock_enable_gen: RTL and testbench



---
 rtl/clock_enable_gen.sv | 154 +++++++++++++++
 tb/tb_clock_enable_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_gen.sv
// ---------------------------------------------------------------------------
// clock_enable_gen
//
// Purpose:
//   Generates NUM_CH independent divided timebases from one system clock.
//   Each channel produces a one-cycle 'tick' clock-enable pulse every D clk
//   cycles and, optionally, a roughly 50% duty square wave 'sq'. Divide
//   values are written at run time into a pending slot and become active at
//   the channel's next wrap so the period never glitches. A single 'sync'
//   strobe restarts every channel in phase.
//
// Build option:
//   CLKEN_SQUARE_EN  defined   -> square-wave flops are built and drive sq.
//                    undefined -> sq is tied low and no sq flops exist.
//
// Parameters:
//   NUM_CH   number of channels (1..16)
//   CNT_W    divider counter / divide value width
//   RST_DIV  divide value loaded at reset (values below 2 become 2)
//   CH_W     derived channel index width, max(1, $clog2(NUM_CH))
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   en        in   per-channel run enable
//   sync      in   one-cycle strobe, restart all channels at count 0
//   cfg_we    in   divide value write strobe
//   cfg_ch    in   channel index for the write (>= NUM_CH is ignored)
//   cfg_div   in   new divide value (period in clk cycles)
//   tick      out  registered one-cycle pulse per period
//   sq        out  registered square wave
//   cfg_pend  out  high while a written divide value awaits its wrap
// ---------------------------------------------------------------------------
module clock_enable_gen #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 27,
  parameter int RST_DIV = 100000000,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] cfg_pend
);

  // A divide value below 2 cannot produce a distinct pulse and gap, so both
  // the reset value and every written value are lifted to 2.
  localparam logic [CNT_W-1:0] RST_D = (RST_DIV < 2) ? CNT_W'(2) : CNT_W'(RST_DIV);

  logic [CNT_W-1:0] w_cfgDivClamped;
  logic             w_chValid;

  assign w_cfgDivClamped = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
  assign w_chValid       = (int'(cfg_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_nxt;
    logic             r_pend;
    logic             r_tick;
    logic             w_wr;
    logic             w_wrap;

    assign w_wr   = cfg_we && w_chValid && (cfg_ch == CH_W'(i));
    assign w_wrap = (r_cnt == (r_div - CNT_W'(1)));

    // Counter, active/pending divide value and tick for this channel.
    // sync beats the enable and promotes a pending value at once; a write in
    // the sync cycle itself goes straight into the active divide value.
    // Outside sync, a write is applied after the wrap logic so that a write
    // landing on the wrap cycle stays pending for the following wrap.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt  <= '0;
        r_div  <= RST_D;
        r_nxt  <= RST_D;
        r_pend <= 1'b0;
        r_tick <= 1'b0;
      end else if (sync) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_pend <= 1'b0;
        if (w_wr) begin
          r_div <= w_cfgDivClamped;
          r_nxt <= w_cfgDivClamped;
        end else if (r_pend) begin
          r_div <= r_nxt;
        end
      end else begin
        if (en[i]) begin
          if (w_wrap) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            if (r_pend) begin
              r_div  <= r_nxt;
              r_pend <= 1'b0;
            end
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
          end
        end else begin
          r_tick <= 1'b0;
        end
        if (w_wr) begin
          r_nxt  <= w_cfgDivClamped;
          r_pend <= 1'b1;
        end
      end
    end

    assign tick[i]     = r_tick;
    assign cfg_pend[i] = r_pend;

`ifdef CLKEN_SQUARE_EN
    logic r_sq;
    logic w_sqClr;

    // Clearing at count (D>>1)-1 keeps sq high for D>>1 cycles; the compare
    // uses the active divide value of the running period.
    assign w_sqClr = (r_cnt == ((r_div >> 1) - CNT_W'(1)));

    // Square wave rises with tick at the wrap, falls mid-period, holds while
    // the channel is disabled and is forced low by sync.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sq <= 1'b0;
      end else if (sync) begin
        r_sq <= 1'b0;
      end else if (en[i]) begin
        if (w_wrap) begin
          r_sq <= 1'b1;
        end else if (w_sqClr) begin
          r_sq <= 1'b0;
        end
      end
    end

    assign sq[i] = r_sq;
`endif
  end

`ifndef CLKEN_SQUARE_EN
  assign sq = '0;
`endif

endmodule

// File: tb/tb_clock_enable_gen.sv
// ---------------------------------------------------------------------------
// tb_clock_enable_gen
//
// Directed bench for clock_enable_gen with NUM_CH=4, CNT_W=8, RST_DIV=10.
// Expected tick cycles are pushed into per-channel queues as stimulus is
// issued; a monitor pops and compares whenever a tick is seen (or one is
// overdue). Cycle N means the clk period following rising edge N, where
// edge 1 is the first edge after reset release.
// ---------------------------------------------------------------------------
module tb_clock_enable_gen;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int RST_DIV = 10;
  localparam int CH_W    = 2;

  logic              clk    = 1'b0;
  logic              rst    = 1'b0;
  logic [NUM_CH-1:0] en     = '0;
  logic              sync   = 1'b0;
  logic              cfgWe  = 1'b0;
  logic [CH_W-1:0]   cfgCh  = '0;
  logic [CNT_W-1:0]  cfgDiv = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] cfgPend;

  int cyc         = 0;
  int testsRun    = 0;
  int testsFailed = 0;
  int expQ[NUM_CH][$];

  clock_enable_gen #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .RST_DIV(RST_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .cfg_we  (cfgWe),
    .cfg_ch  (cfgCh),
    .cfg_div (cfgDiv),
    .tick    (tick),
    .sq      (sq),
    .cfg_pend(cfgPend)
  );

  always #5 clk = ~clk;

  // Cycle number relative to the last reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every seen tick must match the head of its channel queue, and
  // an expected tick whose cycle has come without a pulse is a miss.
  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (tick[c]) begin
          if (expQ[c].size() == 0)
            checkOutput($sformatf("tick%0d unexpected @%0d", c, cyc), 32'(tick[c]), 0);
          else
            checkOutput($sformatf("tick%0d time", c), cyc, expQ[c].pop_front());
        end else if (expQ[c].size() > 0 && expQ[c][0] <= cyc) begin
          checkOutput($sformatf("tick%0d missing @%0d", c, expQ[c][0]), 32'(tick[c]), 1);
          void'(expQ[c].pop_front());
        end
      end
    end
  end

  task automatic gotoCycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pushTicks(input int ch, input int first, input int step, input int last);
    for (int t = first; t <= last; t += step) expQ[ch].push_back(t);
  endtask

  // Drives one cycle of write and/or sync at negedge of cycle atCyc, so the
  // DUT samples it on edge atCyc+1.
  task automatic applyStimulus(input int atCyc, input bit doWrite, input int ch,
                               input int div, input bit doSync);
    gotoCycle(atCyc);
    cfgWe  = doWrite;
    cfgCh  = CH_W'(ch);
    cfgDiv = CNT_W'(div);
    sync   = doSync;
    @(negedge clk);
    cfgWe  = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic checkPend(input int n, input logic [NUM_CH-1:0] expected);
    gotoCycle(n);
    checkOutput($sformatf("cfg_pend @%0d", n), 32'(cfgPend), 32'(expected));
  endtask

  task automatic checkSq(input int n, input int ch, input logic expected);
    logic e;
    gotoCycle(n);
`ifdef CLKEN_SQUARE_EN
    e = expected;
`else
    e = 1'b0;
`endif
    checkOutput($sformatf("sq%0d @%0d", ch, n), 32'(sq[ch]), 32'(e));
  endtask

  initial begin : watchdog
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    en = '1;
    repeat (2) @(negedge clk);
    checkOutput("reset tick", 32'(tick), 0);
    checkOutput("reset sq", 32'(sq), 0);
    checkOutput("reset cfg_pend", 32'(cfgPend), 0);

    pushTicks(0, 10, 10, 40);
    pushTicks(1, 10, 10, 10);
    pushTicks(2, 10, 10, 20);
    pushTicks(3, 10, 10, 20);
    rst = 1'b1;

    // ch1 gets D=4 at cnt=3; active from the wrap at 10.
    applyStimulus(3, 1'b1, 1, 4, 1'b0);
    pushTicks(1, 14, 4, 42);
    checkPend(4, 4'b0010);
    checkPend(9, 4'b0010);
    checkSq(9, 0, 1'b0);
    checkPend(10, 4'b0000);
    checkSq(10, 0, 1'b1);

    // ch2 written with 0 then 1; both clamp to 2.
    checkSq(11, 1, 1'b1);
    applyStimulus(11, 1'b1, 2, 0, 1'b0);
    checkSq(12, 1, 1'b0);
    checkPend(12, 4'b0100);
    applyStimulus(12, 1'b1, 2, 1, 1'b0);
    pushTicks(2, 22, 2, 42);
    checkPend(13, 4'b0100);
    checkSq(14, 0, 1'b1);
    checkSq(15, 0, 1'b0);
    checkPend(20, 4'b0000);
    checkSq(20, 2, 1'b1);
    checkSq(21, 2, 1'b0);
    checkSq(22, 2, 1'b1);

    // ch3 disabled for edges 24..30: tick slips from 30 to 37.
    gotoCycle(23);
    en[3] = 1'b0;
    pushTicks(3, 37, 10, 37);
    checkSq(28, 3, 1'b1);
    checkSq(28, 0, 1'b0);
    gotoCycle(30);
    en[3] = 1'b1;
    checkSq(31, 3, 1'b1);
    checkSq(32, 3, 1'b0);

    // Pending D=6 on ch0, sync two cycles later at edge 44.
    applyStimulus(41, 1'b1, 0, 6, 1'b0);
    pushTicks(0, 50, 6, 56);
    pushTicks(1, 48, 4, 68);
    pushTicks(2, 46, 2, 70);
    pushTicks(3, 54, 10, 64);
    checkPend(42, 4'b0001);
    applyStimulus(43, 1'b0, 0, 0, 1'b1);
    checkPend(44, 4'b0000);
    checkOutput("sq after sync @44", 32'(sq), 0);

    // ch0: D=8 pending, then D=3 written on the wrap cycle (edge 56).
    applyStimulus(51, 1'b1, 0, 8, 1'b0);
    pushTicks(0, 64, 3, 70);
    checkPend(52, 4'b0001);
    applyStimulus(55, 1'b1, 0, 3, 1'b0);
    checkPend(56, 4'b0001);
    checkPend(63, 4'b0001);
    checkPend(64, 4'b0000);

    // sync together with a write of D=5 to ch3 at edge 72.
    applyStimulus(71, 1'b1, 3, 5, 1'b1);
    pushTicks(0, 75, 3, 81);
    pushTicks(1, 76, 4, 80);
    pushTicks(2, 74, 2, 82);
    pushTicks(3, 77, 5, 82);
    checkPend(72, 4'b0000);
    checkOutput("sq after sync @72", 32'(sq), 0);

    // Pending write on ch1, then asynchronous reset mid-period.
    applyStimulus(80, 1'b1, 1, 7, 1'b0);
    checkPend(82, 4'b0010);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset tick", 32'(tick), 0);
    checkOutput("async reset sq", 32'(sq), 0);
    checkOutput("async reset cfg_pend", 32'(cfgPend), 0);
    for (int c = 0; c < NUM_CH; c++) expQ[c].delete();
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) pushTicks(c, 10, 10, 20);
    rst = 1'b1;
    checkPend(5, 4'b0000);
    checkSq(10, 1, 1'b1);
    checkSq(15, 1, 1'b0);
    gotoCycle(25);

    for (int c = 0; c < NUM_CH; c++)
      checkOutput($sformatf("queue%0d drained", c), expQ[c].size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
